// File: rtl/instr_fetch_decoder.sv
// rtl/instr_fetch_decoder.sv - 6502 front end: fetches opcode plus operand bytes and issues one decoded instruction
// Illegal opcodes (low bits 2'b11) latch a sticky flag and park fetch in HALT until reset or pc_load.
module instr_fetch_decoder #(
  parameter int REG_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int OPP_WIDTH    = 5,
  parameter int MAX_OPERANDS = 2,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET = '0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [REG_WIDTH-1:0]              byte_in,
  input  logic                              byte_valid,
  output logic                              fetch_req,
  output logic [ADDR_WIDTH-1:0]             fetch_addr,
  input  logic                              pc_load,
  input  logic [ADDR_WIDTH-1:0]             pc_load_value,
  output logic                              op_valid,
  input  logic                              op_ready,
  output logic [OPP_WIDTH-1:0]              opp,
  output logic [2:0]                        add_mode,
  output logic [REG_WIDTH*MAX_OPERANDS-1:0] operand,
  output logic [1:0]                        n_operands,
  output logic                              illegal
);

  localparam int OPERAND_W = REG_WIDTH * MAX_OPERANDS;

  localparam logic [2:0] AM3_X_IND = 3'd0;
  localparam logic [2:0] AM3_ZPG   = 3'd1;
  localparam logic [2:0] AM3_IMM   = 3'd2;
  localparam logic [2:0] AM3_ABS   = 3'd3;
  localparam logic [2:0] AM3_IND_Y = 3'd4;
  localparam logic [2:0] AM3_ZPG_X = 3'd5;
  localparam logic [2:0] AM3_ABS_Y = 3'd6;
  localparam logic [2:0] AM3_ABS_X = 3'd7;

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    ISSUE     = 2'd2,
    HALT      = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [OPP_WIDTH-1:0]    opp_q, opp_d;
  logic [2:0]              add_mode_q, add_mode_d;
  logic [OPERAND_W-1:0]    operand_q, operand_d;
  logic [1:0]              n_operands_q, n_operands_d;
  logic [1:0]              arg_idx_q, arg_idx_d;
  logic                    illegal_q, illegal_d;
  logic                    fetch_req_q, fetch_req_d;
  logic                    op_valid_q, op_valid_d;
  logic                    accept;
  logic [1:0]              byte_count;

  // Absolute modes carry a 16-bit address; every other mode carries one byte.
  function automatic logic [1:0] operand_count(input logic [2:0] am);
    logic [1:0] raw;
    case (am)
      AM3_ABS, AM3_ABS_Y, AM3_ABS_X:                      raw = 2'd2;
      AM3_X_IND, AM3_ZPG, AM3_IMM, AM3_IND_Y, AM3_ZPG_X: raw = 2'd1;
      default:                                            raw = 2'd1;
    endcase
    if (int'(raw) > MAX_OPERANDS) raw = 2'(MAX_OPERANDS);
    return raw;
  endfunction

  assign accept     = fetch_req_q & byte_valid;
  assign byte_count = operand_count(byte_in[4:2]);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    opp_d        = opp_q;
    add_mode_d   = add_mode_q;
    operand_d    = operand_q;
    n_operands_d = n_operands_q;
    arg_idx_d    = arg_idx_q;
    illegal_d    = illegal_q;
    fetch_req_d  = fetch_req_q;
    op_valid_d   = op_valid_q;

    if (pc_load) begin
      // Redirect wins over everything, including a byte offered this cycle.
      pc_d        = pc_load_value;
      state_d     = FETCH_OP;
      arg_idx_d   = 2'd0;
      fetch_req_d = 1'b1;
      op_valid_d  = 1'b0;
    end else begin
      case (state_q)
        FETCH_OP: begin
          fetch_req_d = 1'b1;
          if (accept) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
            if (byte_in[1:0] == 2'b11) begin
              illegal_d   = 1'b1;
              state_d     = HALT;
              fetch_req_d = 1'b0;
            end else begin
              opp_d        = OPP_WIDTH'({byte_in[7:5], byte_in[1:0]});
              add_mode_d   = byte_in[4:2];
              operand_d    = '0;
              n_operands_d = byte_count;
              arg_idx_d    = 2'd0;
              if (byte_count != 2'd0) begin
                state_d = FETCH_ARG;
              end else begin
                state_d     = ISSUE;
                fetch_req_d = 1'b0;
                op_valid_d  = 1'b1;
              end
            end
          end
        end

        FETCH_ARG: begin
          if (accept) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
            for (int k = 0; k < MAX_OPERANDS; k++) begin
              if (arg_idx_q == 2'(k)) operand_d[k*REG_WIDTH +: REG_WIDTH] = byte_in;
            end
            arg_idx_d = arg_idx_q + 2'd1;
            if (arg_idx_q + 2'd1 == n_operands_q) begin
              state_d     = ISSUE;
              fetch_req_d = 1'b0;
              op_valid_d  = 1'b1;
            end
          end
        end

        ISSUE: begin
          if (op_ready) begin
            state_d     = FETCH_OP;
            op_valid_d  = 1'b0;
            fetch_req_d = 1'b1;
          end
        end

        HALT: begin
          fetch_req_d = 1'b0;
          op_valid_d  = 1'b0;
        end

        default: begin
          state_d     = FETCH_OP;
          fetch_req_d = 1'b0;
          op_valid_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FETCH_OP;
      pc_q         <= PC_RESET;
      opp_q        <= '0;
      add_mode_q   <= '0;
      operand_q    <= '0;
      n_operands_q <= '0;
      arg_idx_q    <= '0;
      illegal_q    <= 1'b0;
      fetch_req_q  <= 1'b0;
      op_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      opp_q        <= opp_d;
      add_mode_q   <= add_mode_d;
      operand_q    <= operand_d;
      n_operands_q <= n_operands_d;
      arg_idx_q    <= arg_idx_d;
      illegal_q    <= illegal_d;
      fetch_req_q  <= fetch_req_d;
      op_valid_q   <= op_valid_d;
    end
  end

  assign fetch_req  = fetch_req_q;
  assign fetch_addr = pc_q;
  assign op_valid   = op_valid_q;
  assign opp        = opp_q;
  assign add_mode   = add_mode_q;
  assign operand    = operand_q;
  assign n_operands = n_operands_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_instr_fetch_decoder.sv
// tb/tb_instr_fetch_decoder.sv - scoreboard bench for instr_fetch_decoder
module tb_instr_fetch_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic        op_valid;
  logic        op_ready;
  logic [4:0]  opp;
  logic [2:0]  add_mode;
  logic [15:0] operand;
  logic [1:0]  n_operands;
  logic        illegal;

  typedef struct packed {
    logic [4:0]  opp;
    logic [2:0]  am;
    logic [15:0] operand;
    logic [1:0]  n;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  instr_fetch_decoder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .opp           (opp),
    .add_mode      (add_mode),
    .operand       (operand),
    .n_operands    (n_operands),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each op_valid/op_ready handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && op_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL spurious_op_valid: got op_valid=1 expected 0 with no pending instruction (t=%0t)", $time);
        end else if (op_ready) begin
          e = sb.pop_front();
          check("sb_opp", 32'(opp), 32'(e.opp));
          check("sb_add_mode", 32'(add_mode), 32'(e.am));
          check("sb_operand", 32'(operand), 32'(e.operand));
          check("sb_n_operands", 32'(n_operands), 32'(e.n));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic [15:0] exp_addr, input int gap);
    int waited = 0;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    while (!fetch_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("fetch_req_before_byte", 32'(fetch_req), 32'd1);
    check("fetch_addr_before_byte", 32'(fetch_addr), 32'(exp_addr));
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic do_pc_load(input logic [15:0] v, input logic bv);
    pc_load       = 1'b1;
    pc_load_value = v;
    byte_valid    = bv;
    byte_in       = 8'hEA;
    @(negedge clk);
    pc_load    = 1'b0;
    byte_valid = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    byte_in       = 8'h00;
    byte_valid    = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = 16'h0000;
    op_ready      = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_opp", 32'(opp), 32'd0);
    check("rst_add_mode", 32'(add_mode), 32'd0);
    check("rst_operand", 32'(operand), 32'd0);
    check("rst_n_operands", 32'(n_operands), 32'd0);
    check("rst_fetch_addr", 32'(fetch_addr), 32'h0000);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_fetch_req_after_release", 32'(fetch_req), 32'd1);

    // 1: LDA #imm at 0x8000
    do_pc_load(16'h8000, 1'b0);
    check("t1_fetch_addr_load", 32'(fetch_addr), 32'h8000);
    sb.push_back('{opp: 5'b10101, am: 3'b010, operand: 16'h0042, n: 2'd1});
    send_byte(8'hA9, 16'h8000, 0);
    send_byte(8'h42, 16'h8001, 0);
    check("t1_op_valid", 32'(op_valid), 32'd1);
    check("t1_fetch_addr", 32'(fetch_addr), 32'h8002);
    check("t1_fetch_req_issue", 32'(fetch_req), 32'd0);
    @(negedge clk);
    check("t1_op_valid_drop", 32'(op_valid), 32'd0);

    // 2: LDA abs with 3-cycle byte gaps
    sb.push_back('{opp: 5'b10101, am: 3'b011, operand: 16'h1234, n: 2'd2});
    send_byte(8'hAD, 16'h8002, 3);
    send_byte(8'h34, 16'h8003, 3);
    send_byte(8'h12, 16'h8004, 3);
    check("t2_latency_op_valid", 32'(op_valid), 32'd1);
    check("t2_fetch_addr", 32'(fetch_addr), 32'h8005);
    @(negedge clk);

    // 3: back-pressure in ISSUE
    op_ready = 1'b0;
    sb.push_back('{opp: 5'b10101, am: 3'b001, operand: 16'h0010, n: 2'd1});
    send_byte(8'hA5, 16'h8005, 0);
    send_byte(8'h10, 16'h8006, 0);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_op_valid", 32'(op_valid), 32'd1);
      check("t3_hold_fetch_req", 32'(fetch_req), 32'd0);
      check("t3_hold_fetch_addr", 32'(fetch_addr), 32'h8007);
      check("t3_hold_operand", 32'(operand), 32'h0010);
      check("t3_hold_opp", 32'(opp), 32'b10101);
      check("t3_hold_add_mode", 32'(add_mode), 32'b001);
      byte_valid = 1'b1;
      byte_in    = 8'hFF;
      @(negedge clk);
      byte_valid = 1'b0;
    end
    op_ready = 1'b1;
    @(negedge clk);
    check("t3_release_op_valid", 32'(op_valid), 32'd0);
    check("t3_release_fetch_req", 32'(fetch_req), 32'd1);

    // 4: illegal opcode halts, pc_load resumes with flag sticky
    send_byte(8'h03, 16'h8007, 0);
    check("t4_illegal", 32'(illegal), 32'd1);
    check("t4_fetch_req", 32'(fetch_req), 32'd0);
    check("t4_fetch_addr", 32'(fetch_addr), 32'h8008);
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1;
      byte_in    = 8'hA9;
      @(negedge clk);
      byte_valid = 1'b0;
      check("t4_halt_op_valid", 32'(op_valid), 32'd0);
      check("t4_halt_fetch_req", 32'(fetch_req), 32'd0);
      check("t4_halt_fetch_addr", 32'(fetch_addr), 32'h8008);
    end
    do_pc_load(16'h9000, 1'b0);
    check("t4_resume_addr", 32'(fetch_addr), 32'h9000);
    check("t4_resume_fetch_req", 32'(fetch_req), 32'd1);
    check("t4_illegal_sticky", 32'(illegal), 32'd1);
    sb.push_back('{opp: 5'b10101, am: 3'b010, operand: 16'h0077, n: 2'd1});
    send_byte(8'hA9, 16'h9000, 0);
    send_byte(8'h77, 16'h9001, 0);
    check("t4_op_valid", 32'(op_valid), 32'd1);
    @(negedge clk);

    // 5: PC wrap FFFF -> 0000
    do_pc_load(16'hFFFF, 1'b0);
    sb.push_back('{opp: 5'b10101, am: 3'b011, operand: 16'h8000, n: 2'd2});
    send_byte(8'hAD, 16'hFFFF, 0);
    send_byte(8'h00, 16'h0000, 0);
    send_byte(8'h80, 16'h0001, 0);
    check("t5_op_valid", 32'(op_valid), 32'd1);
    check("t5_fetch_addr", 32'(fetch_addr), 32'h0002);
    @(negedge clk);

    // 6a: pc_load mid-FETCH_ARG drops the partial instruction
    send_byte(8'hAD, 16'h0002, 0);
    send_byte(8'h11, 16'h0003, 0);
    do_pc_load(16'h4000, 1'b1);
    check("t6a_fetch_addr", 32'(fetch_addr), 32'h4000);
    check("t6a_op_valid", 32'(op_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("t6a_no_issue", 32'(op_valid), 32'd0);
    end
    sb.push_back('{opp: 5'b10101, am: 3'b010, operand: 16'h0055, n: 2'd1});
    send_byte(8'hA9, 16'h4000, 0);
    send_byte(8'h55, 16'h4001, 0);
    @(negedge clk);

    // 6b: asynchronous reset mid-FETCH_ARG
    send_byte(8'hAD, 16'h4002, 0);
    send_byte(8'h22, 16'h4003, 0);
    reset_n = 1'b0;
    #1;
    check("t6b_op_valid", 32'(op_valid), 32'd0);
    check("t6b_fetch_req", 32'(fetch_req), 32'd0);
    check("t6b_fetch_addr", 32'(fetch_addr), 32'h0000);
    check("t6b_opp", 32'(opp), 32'd0);
    check("t6b_add_mode", 32'(add_mode), 32'd0);
    check("t6b_operand", 32'(operand), 32'd0);
    check("t6b_n_operands", 32'(n_operands), 32'd0);
    check("t6b_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t6b_fetch_req_release", 32'(fetch_req), 32'd1);
    check("t6b_fetch_addr_release", 32'(fetch_addr), 32'h0000);
    sb.push_back('{opp: 5'b10101, am: 3'b010, operand: 16'h0001, n: 2'd1});
    send_byte(8'hA9, 16'h0000, 0);
    send_byte(8'h01, 16'h0001, 0);
    repeat (2) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
